lsu_byte_sequencer: RTL

Load/store sequencer that sits between the CPU's memory-stage request and a byte-wide synchronous data memory. It accepts one byte, halfword or word request per handshake and issues 1, 2 or 4 sequential byte accesses. For loads, it assembles the bytes into a zero- or sign-extended 32-bit result. For stores, it splits the write data into bytes. It is the initiator side of the data-memory interface and replaces the single-cycle combined access when the memory is a narrow multi-cycle array.

---
 rtl/lsu_byte_sequencer.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/lsu_byte_sequencer.sv
// Load/store byte sequencer: turns one byte/halfword/word request into 1, 2 or 4
// sequential byte accesses on a byte-wide synchronous memory. Loads are
// reassembled little-endian and zero/sign-extended; stores are split into bytes.
module lsu_byte_sequencer #(
  parameter int ADDR_W = 32
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_width,
  input  logic              req_sign,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, RESP} stateE;

  stateE             state, stateNext;
  logic [1:0]        byteIdx;      // index of the byte strobed this cycle
  logic [1:0]        lastIdx;      // N-1 for the latched width
  logic [1:0]        nextIdx;
  logic [1:0]        captIdx;      // index of the byte present on mem_rdata
  logic              isWrite;
  logic              isSigned;
  logic [ADDR_W-1:0] baseAddr;
  logic [31:0]       storeData;
  logic [31:0]       assembly;     // load bytes gathered so far
  logic [31:0]       merged;       // assembly with the byte on mem_rdata inserted
  logic [31:0]       extended;
  logic              lastByte;

  assign lastByte = (byteIdx == lastIdx);
  assign nextIdx  = byteIdx + 2'd1;

  // State register.
  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    if (!Reset) state <= IDLE;
    else        state <= stateNext;
  end

  // Next-state decode and handshake outputs.
  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    stateNext  = state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) stateNext = ISSUE;
      end
      ISSUE: if (lastByte) stateNext = isWrite ? RESP : DRAIN;
      DRAIN: stateNext = RESP;
      RESP: begin
        resp_valid = 1'b1;
        stateNext  = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  // Insert the byte returned for the previous strobe, then apply extension.
  always_comb begin
    captIdx = (state == DRAIN) ? lastIdx : byteIdx - 2'd1;
    merged  = assembly;
    merged[{captIdx, 3'b000} +: 8] = mem_rdata;
    case (lastIdx)
      2'd0:    extended = {{24{isSigned & merged[7]}},  merged[7:0]};
      2'd1:    extended = {{16{isSigned & merged[15]}}, merged[15:0]};
      default: extended = merged;
    endcase
  end

  // Request latch, byte sequencing, load assembly and registered memory port.
  always_ff @(posedge CLK) begin
    if (!Reset) begin
      byteIdx    <= '0;
      lastIdx    <= '0;
      isWrite    <= 1'b0;
      isSigned   <= 1'b0;
      baseAddr   <= '0;
      storeData  <= '0;
      assembly   <= '0;
      resp_rdata <= '0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            isWrite   <= req_write;
            isSigned  <= req_sign;
            baseAddr  <= req_addr;
            storeData <= req_wdata;
            byteIdx   <= 2'd0;
            assembly  <= '0;
            case (req_width)
              2'b00:   lastIdx <= 2'd0;
              2'b01:   lastIdx <= 2'd1;
              default: lastIdx <= 2'd3;
            endcase
            mem_en    <= 1'b1;
            mem_we    <= req_write;
            mem_addr  <= req_addr;
            mem_wdata <= req_wdata[7:0];
          end
        end
        ISSUE: begin
          // Byte k-1 is on mem_rdata while byte k is being strobed.
          if (!isWrite && byteIdx != 2'd0) assembly <= merged;
          if (lastByte) begin
            mem_en <= 1'b0;
            mem_we <= 1'b0;
          end else begin
            byteIdx   <= nextIdx;
            mem_addr  <= baseAddr + ADDR_W'(nextIdx);
            mem_wdata <= storeData[{nextIdx, 3'b000} +: 8];
          end
        end
        DRAIN: begin
          assembly   <= merged;
          resp_rdata <= extended;
        end
        default: ;
      endcase
    end
  end

endmodule
